// File: rtl/ws2812_driver.sv
// WS2812 serial driver: pops bytes from a non-show-ahead RX FIFO and emits
// pulse-width-coded bits MSB first, with a latch period after each frame.
module ws2812_driver #(
  parameter int unsigned NUM_LEDS   = 8,
  parameter int unsigned T_BIT      = 63,
  parameter int unsigned T0H        = 20,
  parameter int unsigned T1H        = 40,
  parameter int unsigned RES_CYCLES = 3000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] fifo_rdata,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  output logic       dout,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int unsigned FRAME_BYTES = NUM_LEDS * 3;
  localparam int unsigned CYC_MAX     = (T_BIT > RES_CYCLES) ? T_BIT : RES_CYCLES;
  localparam int unsigned CYC_W       = $clog2(CYC_MAX + 1);
  localparam int unsigned BCNT_W      = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

  localparam logic [CYC_W-1:0]  BIT_LAST  = CYC_W'(T_BIT - 1);
  localparam logic [CYC_W-1:0]  PF_CUTOFF = CYC_W'(T_BIT - 2);
  localparam logic [CYC_W-1:0]  RES_LAST  = CYC_W'(RES_CYCLES - 1);
  localparam logic [CYC_W-1:0]  HI_ONE    = CYC_W'(T1H);
  localparam logic [CYC_W-1:0]  HI_ZERO   = CYC_W'(T0H);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(FRAME_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_LOAD, S_BIT, S_WAIT, S_LATCH
  } state_t;

  state_t            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        pf_data_q, pf_data_d;
  logic              pf_valid_q, pf_valid_d;
  logic              pf_req_q, pf_req_d;
  logic              pf_cap_q, pf_cap_d;
  logic              fifo_rd_q, fifo_rd_d;
  logic              dout_q, dout_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              underrun_q, underrun_d;

  logic [CYC_W-1:0]  cyc_inc;
  logic [CYC_W-1:0]  hi_len;
  logic              last_byte;

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    bit_idx_d    = bit_idx_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    pf_data_d    = pf_data_q;
    pf_valid_d   = pf_valid_q;
    pf_req_d     = 1'b0;
    pf_cap_d     = pf_req_q;
    fifo_rd_d    = 1'b0;
    dout_d       = 1'b0;
    frame_done_d = 1'b0;
    underrun_d   = underrun_q;

    cyc_inc   = cyc_q + CYC_W'(1);
    hi_len    = shift_q[7] ? HI_ONE : HI_ZERO;
    last_byte = (byte_cnt_q == LAST_BYTE);

    // Prefetch data lands on fifo_rdata two cycles after the strobe is raised
    if (pf_cap_q) begin
      pf_data_d  = fifo_rdata;
      pf_valid_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_d  = 1'b1;
          underrun_d = 1'b0;
          byte_cnt_d = '0;
          state_d    = S_RD;
        end
      end
      S_RD: state_d = S_LOAD;
      S_LOAD: begin
        shift_d   = fifo_rdata;
        bit_idx_d = '0;
        cyc_d     = '0;
        dout_d    = 1'b1;
        state_d   = S_BIT;
      end
      S_BIT: begin
        // No new prefetch in the last two cycles of a byte, so any pending
        // read has its data on fifo_rdata by the byte boundary.
        if (!pf_valid_q && !pf_req_q && !pf_cap_q && !fifo_empty && !last_byte &&
            !(bit_idx_q == 3'd7 && cyc_q >= PF_CUTOFF)) begin
          fifo_rd_d = 1'b1;
          pf_req_d  = 1'b1;
        end
        if (cyc_q == BIT_LAST) begin
          cyc_d = '0;
          if (bit_idx_q != 3'd7) begin
            shift_d   = {shift_q[6:0], 1'b0};
            bit_idx_d = bit_idx_q + 3'd1;
            dout_d    = 1'b1;
          end else if (last_byte) begin
            state_d = S_LATCH;
          end else if (pf_valid_q || pf_cap_q) begin
            shift_d    = pf_valid_q ? pf_data_q : fifo_rdata;
            pf_valid_d = 1'b0;
            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
            bit_idx_d  = '0;
            dout_d     = 1'b1;
          end else begin
            underrun_d = 1'b1;
            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
            state_d    = S_WAIT;
          end
        end else begin
          cyc_d  = cyc_inc;
          dout_d = (cyc_inc < hi_len);
        end
      end
      S_WAIT: begin
        if (!fifo_empty) begin
          fifo_rd_d = 1'b1;
          state_d   = S_RD;
        end
      end
      S_LATCH: begin
        if (cyc_q == RES_LAST) begin
          cyc_d        = '0;
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cyc_d = cyc_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // busy is held through the frame_done pulse so both fall together
    busy_d = (state_d != S_IDLE) || frame_done_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cyc_q        <= '0;
      bit_idx_q    <= '0;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      pf_data_q    <= '0;
      pf_valid_q   <= 1'b0;
      pf_req_q     <= 1'b0;
      pf_cap_q     <= 1'b0;
      fifo_rd_q    <= 1'b0;
      dout_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      bit_idx_q    <= bit_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      pf_data_q    <= pf_data_d;
      pf_valid_q   <= pf_valid_d;
      pf_req_q     <= pf_req_d;
      pf_cap_q     <= pf_cap_d;
      fifo_rd_q    <= fifo_rd_d;
      dout_q       <= dout_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign fifo_rd    = fifo_rd_q;
  assign dout       = dout_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_ws2812_driver.sv
// Bench for ws2812_driver: FIFO model feeding the DUT, waveform decoder
// scoreboarding decoded bytes and frame timing against queued expectations.
module tb_ws2812_driver;

  localparam int unsigned NUM_LEDS = 1;
  localparam int unsigned T_BIT    = 63;
  localparam int unsigned T0H      = 20;
  localparam int unsigned T1H      = 40;
  localparam int unsigned RES      = 3000;
  localparam int unsigned FB       = NUM_LEDS * 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] fifo_rdata = 8'h00;
  logic       fifo_empty;
  logic       fifo_rd, dout, busy, frame_done, underrun;

  always #5 clk = ~clk;

  ws2812_driver #(
    .NUM_LEDS(NUM_LEDS), .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .RES_CYCLES(RES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
    .fifo_rd(fifo_rd), .dout(dout), .busy(busy), .frame_done(frame_done),
    .underrun(underrun)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Non-show-ahead FIFO model
  logic [7:0] mem [0:1023];
  int push_cnt = 0;
  int pop_cnt  = 0;
  assign fifo_empty = (push_cnt == pop_cnt);

  always @(posedge clk) begin
    if (rst_n && fifo_rd === 1'b1) begin
      check("rd_while_empty", int'(fifo_empty), 0);
      if (!fifo_empty) begin
        fifo_rdata <= mem[pop_cnt % 1024];
        pop_cnt    <= pop_cnt + 1;
      end
    end
  end

  typedef struct { bit und; bit gapless; } fexp_t;
  logic [7:0] exp_q[$];
  fexp_t      fexp_q[$];

  task automatic push_byte(input logic [7:0] b);
    mem[push_cnt % 1024] = b;
    push_cnt++;
    exp_q.push_back(b);
  endtask

  task automatic push_frame(input bit und, input bit gapless);
    fexp_t f;
    f.und = und;
    f.gapless = gapless;
    fexp_q.push_back(f);
  endtask

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Waveform decoder / scoreboard monitor
  int   frames_done = 0;
  int   mon_bits = 0;
  int   hi_run, nb, first_rise, last_rise, latch_rd;
  bit   have_rise, prev_dout;
  logic [7:0] acc;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_bits = 0; nb = 0; hi_run = 0; have_rise = 0; prev_dout = 0; latch_rd = 0;
    end else begin
      if (dout && !prev_dout) begin
        if (have_rise) check("bit_period_min", int'((cyc_cnt - last_rise) >= T_BIT), 1);
        if (mon_bits == 0) first_rise = cyc_cnt;
        last_rise = cyc_cnt;
        have_rise = 1;
        hi_run = 0;
      end
      if (dout) hi_run++;
      if (!dout && prev_dout) begin
        n_tests++;
        if (hi_run != T0H && hi_run != T1H) begin
          n_fail++;
          $display("FAIL high_width: got %0d expected %0d or %0d", hi_run, T0H, T1H);
        end
        acc = {acc[6:0], (hi_run == T1H)};
        nb++;
        mon_bits++;
        if (nb == 8) begin
          nb = 0;
          check("byte_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check("byte_value", int'(acc), int'(exp_q.pop_front()));
        end
      end
      if (fifo_rd && mon_bits == FB * 8) latch_rd++;
      if (frame_done) begin
        fexp_t f;
        check("frame_bits", mon_bits, FB * 8);
        check("latch_len", cyc_cnt - last_rise, T_BIT + RES);
        check("busy_at_done", int'(busy), 1);
        check("no_rd_in_latch", latch_rd, 0);
        check("frame_expected", int'(fexp_q.size() > 0), 1);
        if (fexp_q.size() > 0) begin
          f = fexp_q.pop_front();
          check("underrun_flag", int'(underrun), int'(f.und));
          if (f.gapless) check("data_span", last_rise - first_rise, (FB * 8 - 1) * T_BIT);
        end
        frames_done++;
        mon_bits = 0; nb = 0; have_rise = 0; latch_rd = 0;
      end
      prev_dout = dout;
    end
  end

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (frames_done < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("frame_timeout", int'(frames_done >= n), 1);
  endtask

  int exp_frames = 0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_dout", int'(dout), 0);
    check("rst_fifo_rd", int'(fifo_rd), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_underrun", int'(underrun), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_fifo_rd", int'(fifo_rd), 0);

    // Start latency and the 0xFF/0x00/0xA5 pattern
    push_frame(0, 1);
    push_byte(8'hFF);
    @(negedge clk);
    check("start_rd_e0", int'(fifo_rd), 1);
    check("start_dout_e0", int'(dout), 0);
    push_byte(8'h00);
    push_byte(8'hA5);
    @(negedge clk);
    check("start_rd_e1", int'(fifo_rd), 0);
    check("start_dout_e1", int'(dout), 0);
    @(negedge clk);
    check("start_dout_e2", int'(dout), 1);
    check("start_busy", int'(busy), 1);
    exp_frames++;
    wait_frames(exp_frames, 6000);
    @(negedge clk);
    check("busy_after_done", int'(busy), 0);
    check("done_pulse_width", int'(frame_done), 0);

    // Byte boundary through the prefetch register
    push_frame(0, 1);
    push_byte(8'h01); push_byte(8'h80); push_byte(8'h3C);
    exp_frames++;
    wait_frames(exp_frames, 6000);

    // Underrun: one byte, the rest arrives late
    push_frame(1, 0);
    push_byte(8'h5A);
    repeat (600) @(negedge clk);
    check("underrun_mid", int'(underrun), 1);
    check("wait_dout_low", int'(dout), 0);
    push_byte(8'hC3); push_byte(8'h0F);
    exp_frames++;
    wait_frames(exp_frames, 8000);
    check("underrun_sticky", int'(underrun), 1);
    push_frame(0, 1);
    for (int i = 0; i < FB; i++) push_byte(8'($urandom));
    repeat (3) @(negedge clk);
    check("underrun_cleared", int'(underrun), 0);
    exp_frames++;
    wait_frames(exp_frames, 6000);

    // Reset during bit 5 of the last byte
    for (int i = 0; i < FB; i++) push_byte(8'($urandom));
    begin
      int t = 0;
      while (mon_bits < 22 && t < 3000) begin
        @(negedge clk);
        t++;
      end
      check("reset_point_timeout", int'(mon_bits >= 22), 1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_dout", int'(dout), 0);
    check("midrst_busy", int'(busy), 0);
    @(negedge clk);
    exp_q.delete();
    rst_n = 1'b1;
    push_frame(0, 1);
    for (int i = 0; i < FB; i++) push_byte(8'($urandom));
    exp_frames++;
    wait_frames(exp_frames, 6000);

    // Random back-to-back frames with the FIFO never empty between them
    for (int r = 0; r < 2; r++) begin
      for (int f = 0; f < 2; f++) begin
        push_frame(0, 1);
        for (int i = 0; i < FB; i++) push_byte(8'($urandom));
      end
      exp_frames += 2;
      wait_frames(exp_frames, 12000);
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    check("leftover_bytes", exp_q.size(), 0);
    check("leftover_frames", fexp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
